// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter driving a 4-bit HD44780 bus, one byte as two enable-strobed nibbles.
// Build option: define LCD_ARB_FIXED_PRIORITY_EN to make requester 0 always win a tie.
module lcd_bus_arbiter #(
  parameter int SHORT_WAIT = 0,
  parameter int LONG_WAIT  = 2,
  parameter int WAIT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [3:0] lcd_data,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI_ON,
    ST_HI_OFF,
    ST_LO_ON,
    ST_LO_OFF,
    ST_WAIT
  } state_t;

  localparam logic [WAIT_W-1:0] SHORT_W = WAIT_W'(SHORT_WAIT);
  localparam logic [WAIT_W-1:0] LONG_W  = WAIT_W'(LONG_WAIT);

  state_t            state_q, state_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              grant_q, grant_d;
  logic              lcd_en_q, lcd_en_d;
  logic              lcd_rs_q, lcd_rs_d;
  logic [3:0]        lcd_data_q, lcd_data_d;
`ifndef LCD_ARB_FIXED_PRIORITY_EN
  logic              last_q, last_d;
`endif

  logic              win1;
  logic              accept;
  logic              win_rs;
  logic [7:0]        win_data;
  logic              long_cmd;
  logic [WAIT_W-1:0] load_val;

`ifdef LCD_ARB_FIXED_PRIORITY_EN
  assign win1 = req1_valid & ~req0_valid;
`else
  // On a tie the requester that did not win last time goes next.
  assign win1 = req1_valid & (~req0_valid | ~last_q);
`endif

  assign accept     = ~reset & (state_q == ST_IDLE) & (req0_valid | req1_valid);
  assign req0_ready = accept & ~win1;
  assign req1_ready = accept & win1;
  assign win_rs     = win1 ? req1_rs : req0_rs;
  assign win_data   = win1 ? req1_data : req0_data;

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  assign long_cmd = ~rs_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0);
  assign load_val = long_cmd ? LONG_W : SHORT_W;

  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    data_d     = data_q;
    wait_d     = wait_q;
    grant_d    = grant_q;
    lcd_en_d   = 1'b0;
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
`ifndef LCD_ARB_FIXED_PRIORITY_EN
    last_d     = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rs_d       = win_rs;
          data_d     = win_data;
          grant_d    = win1;
`ifndef LCD_ARB_FIXED_PRIORITY_EN
          last_d     = win1;
`endif
          lcd_en_d   = 1'b1;
          lcd_rs_d   = win_rs;
          lcd_data_d = win_data[7:4];
          state_d    = ST_HI_ON;
        end
      end
      ST_HI_ON: begin
        state_d = ST_HI_OFF;
      end
      ST_HI_OFF: begin
        lcd_en_d   = 1'b1;
        lcd_data_d = data_q[3:0];
        state_d    = ST_LO_ON;
      end
      ST_LO_ON: begin
        state_d = ST_LO_OFF;
      end
      ST_LO_OFF: begin
        wait_d  = load_val;
        state_d = (load_val == '0) ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      grant_q    <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 4'd0;
`ifndef LCD_ARB_FIXED_PRIORITY_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      grant_q    <= grant_d;
      lcd_en_q   <= lcd_en_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
`ifndef LCD_ARB_FIXED_PRIORITY_EN
      last_q     <= last_d;
`endif
    end
  end

  // Byte holding registers need no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    rs_q   <= rs_d;
    data_q <= data_d;
  end

  assign lcd_en   = lcd_en_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_data = lcd_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

endmodule
